// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package imem_loader_pkg;

  // Frame format: 8N1, LSB first.
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Load FSM states.
  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    DONE,
    ERR
  } load_state_e;

  // Receiver states.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_e;

  // Clock cycles per serial bit, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling baud counter, bit shifter.
module uart_rx
  import imem_loader_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int DIV   = baud_div(CLK_HZ, BAUD);
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV + 1);

  // sync_q[1] is the synchronized line, sync_q[2] its previous value.
  logic [2:0]       sync_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  logic line;
  logic fall;
  assign line = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];

  // Two-flop synchronizer plus edge-detect stage; idles high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= 3'b111;
    else       sync_q <= {sync_q[1:0], rxd};
  end

  // Receiver state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Start detect, start-bit validation, data sampling and stop-bit check.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A line back high at mid-start is a glitch: drop it silently.
          state_d = line ? RX_IDLE : RX_BITS;
        end
      end
      RX_BITS: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[7:1]};
          if (bit_q == 3'(DATA_BITS - 1)) state_d = RX_STOP;
          else                            bit_d   = bit_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (line) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Loads a word-count-prefixed little-endian program image from UART into instruction memory.
module uart_imem_loader
  import imem_loader_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rxd,
  input  logic              load_en,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [31:0]       wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk         (clk),
    .rstn        (rstn),
    .rxd         (rxd),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_ferr)
  );

  logic [1:0]        en_sync_q;
  load_state_e       state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       wbuf_q, wbuf_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Two-flop synchronizer for the load_en switch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) en_sync_q <= 2'b00;
    else       en_sync_q <= {en_sync_q[0], load_en};
  end

  // Load FSM and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      lane_q  <= '0;
      wbuf_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      wbuf_q  <= wbuf_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state, byte-lane assembly, write strobe and address/word counters.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    wbuf_d  = wbuf_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    done_d  = done_q;
    err_d   = err_q;
    if (!en_sync_q[1]) begin
      // Switch off: abandon any partial word, keep counters for display.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = COUNT;
          lane_d  = '0;
          waddr_d = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
        COUNT: begin
          if (rx_ferr) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else if (rx_valid) begin
            // 0 encodes a full-depth image; anything larger is clipped to depth.
            if (rx_byte == 8'd0 || int'(rx_byte) > DEPTH) n_d = (ADDR_W + 1)'(DEPTH);
            else                                          n_d = rx_byte[ADDR_W:0];
            state_d = DATA;
          end
        end
        DATA: begin
          if (rx_ferr) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            if (we_q) begin
              cnt_d = cnt_q + 1'b1;
              if (cnt_q + 1'b1 == n_q) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                waddr_d = waddr_q + 1'b1;
              end
            end
            if (rx_valid) begin
              if (lane_q == 2'd3) begin
                we_d    = 1'b1;
                wdata_d = {rx_byte, wbuf_q};
                lane_d  = '0;
              end else begin
                wbuf_d[8*int'(lane_q) +: 8] = rx_byte;
                lane_d = lane_q + 1'b1;
              end
            end
          end
        end
        DONE, ERR: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign we_o       = we_q;
  assign waddr_o    = waddr_q;
  assign wdata_o    = wdata_q;
  assign busy_o     = (state_q == COUNT) || (state_q == DATA);
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign word_cnt_o = cnt_q;

endmodule

// File: doc/uart_imem_loader.md
# uart_imem_loader

Receives a program image over a UART serial line and writes it, word by word, into the CPU's instruction memory. It is the write side of the instruction ROM that the single-cycle CPU top reads by `rom_addr`. It sits between the board's `rxd` pin and the instruction-memory write port, and is enabled by a board switch. It reports progress and status so the top can show it on the seven-segment display.

## Interface
- `CLK_HZ`, default 100_000_000: frequency of `clk`.
- `BAUD`, default 115200: serial bit rate. `BAUD_DIV = (CLK_HZ + BAUD/2) / BAUD` = 868.
- `ADDR_W`, default 6: instruction-memory word-address width. Depth is `2**ADDR_W` = 64.
- `clk`, input, 1: system clock.
- `rstn`, input, 1: reset, asynchronous, active-low.
- `rxd`, input, 1: UART receive line. Asynchronous to `clk`. Idles high.
- `load_en`, input, 1: loader enable (switch). Low forces the IDLE state.
- `we_o`, output, 1: instruction-memory write strobe. One-cycle pulse.
- `waddr_o`, output, `ADDR_W`: write word address.
- `wdata_o`, output, 32: write data. Valid only while `we_o` is high.
- `busy_o`, output, 1: a load is in progress (state COUNT or DATA).
- `done_o`, output, 1: the image loaded completely. Level signal.
- `err_o`, output, 1: framing error. Level signal.
- `word_cnt_o`, output, `ADDR_W+1`: number of words written in the current load.

## Operation
- UART framing is 8N1, LSB first.
- The first byte of a load is the word count `N`. Values 1..63 are used as-is; 0 means 64.
- `4*N` data bytes follow. Words are little-endian: the first byte of each group of four goes to `wdata_o[7:0]`.
- FSM states and transitions:
  - IDLE → COUNT when `load_en` is 1.
  - COUNT → DATA when the count byte is received.
  - DATA: each 4th byte issues one write at `waddr_o`, then `waddr_o` and `word_cnt_o` increment.
  - DATA → DONE after the Nth write.
  - DONE holds until `load_en` falls.
  - Any state → ERR on a framing error (stop bit sampled as 0). ERR holds until `load_en` falls.
  - Any state → IDLE whenever `load_en` is 0.
- Entering COUNT clears `waddr_o`, `word_cnt_o`, the byte-lane index, `done_o` and `err_o`.
- Partial load: if `load_en` falls mid-load, words already written stay in memory, the partial word is discarded, and no further `we_o` is issued.
- Bytes arriving in DONE or ERR are ignored.
- Writes never wrap: the write counter stops at `N`, and `N` is at most 64.
- `err_o` takes priority: a bad stop bit on the last byte yields ERR, no write, and `done_o` stays 0.
- Reset values: `we_o`=0, `waddr_o`=0, `wdata_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0, `word_cnt_o`=0. The FSM resets to IDLE and the receiver to its idle state.

## Timing
- `rxd` passes through a 2-flop synchronizer. Start detection is a falling edge on the synchronized signal.
- Start-bit check at `BAUD_DIV/2` = 434 cycles after the edge. If the line is high, it was a false start and the receiver returns to idle without reporting an error.
- Data bits are sampled every `BAUD_DIV` cycles from the start-bit midpoint. The stop bit is sampled at the same spacing.
- The receiver's `byte_valid` pulses for 1 cycle, in the cycle after the stop-bit sample, with the byte held alongside it.
- `we_o` rises in the cycle after the `byte_valid` of the 4th byte of a word.
- `waddr_o` and `word_cnt_o` update in the cycle after `we_o`.
- `done_o` rises in the same cycle as that final update.
- `load_en` is synchronized with 2 flops. The FSM reacts 2 cycles after a `load_en` edge.
- Reset mid-byte: the receiver and FSM go to idle immediately. A subsequent falling edge of `rxd` starts a new byte.

## Structure
- Shared package `imem_loader_pkg` holds:
  - the state enum `IDLE`, `COUNT`, `DATA`, `DONE`, `ERR`;
  - the `BAUD_DIV` calculation function;
  - the frame-format constants (8 data bits, 1 stop bit).
- Sub-module `uart_rx`:
  - inputs: `clk`, `rstn`, `rxd`;
  - outputs: `byte_o[7:0]`, `byte_valid_o`, `frame_err_o`;
  - contains the synchronizer, baud counter and bit shifter.
- The top module contains the load FSM, the byte-lane assembler and the address/word counters.

## Test plan
- Normal load: `load_en`=1, send 0x02, then bytes 13 00 00 00 93 00 10 00 → writes 0x00000013 at address 0 and 0x00100093 at address 1; `done_o`=1; `word_cnt_o`=2; exactly 2 `we_o` pulses.
- Full depth: count byte 0x00 followed by 256 bytes → 64 writes at addresses 0..63; `done_o`=1; `word_cnt_o`=64; no 65th write.
- Framing error: send a count of 0x01, then a byte whose stop bit is held low → `err_o`=1, `busy_o`=0, no `we_o`. Toggling `load_en` to 0 and back to 1 clears `err_o`.
- Abort: drop `load_en` after 6 of 8 data bytes → 1 write only, return to IDLE, `busy_o`=0, `done_o`=0.
- False start: a 200-cycle low glitch on `rxd` → no `byte_valid`, state unchanged. The next valid byte is received correctly.
- Reset mid-word: assert `rstn`=0 after 2 data bytes → all outputs are 0 on the next cycle. A fresh load afterwards starts at address 0.
